// File: rtl/operand_sel_stage.sv
// operand_sel_stage: N-source, WIDTH-bit operand select registered as a pipeline slice with stall/flush.
// Optional stall-length counter on port stall_cnt, enabled by defining OPSEL_STALL_CNT_EN.
module operand_sel_stage #(
  parameter int               WIDTH   = 32,
  parameter int               NSRC    = 4,
  parameter int               SELW    = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NSRC*WIDTH-1:0] src_data,
  input  logic [SELW-1:0]       sel,
  input  logic                  in_valid,
  input  logic                  stall,
  input  logic                  flush,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  output logic                  out_sel_err
`ifdef OPSEL_STALL_CNT_EN
  ,
  output logic [7:0]            stall_cnt
`endif
);

  logic [WIDTH-1:0] data_d, data_q, sel_word;
  logic             valid_d, valid_q;
  logic             err_d, err_q;
  logic             sel_ok;

  // An unmatched select leaves sel_word at RST_VAL, which is the out-of-range capture value.
  always_comb begin
    sel_word = RST_VAL;
    sel_ok   = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (32'(sel) == i) begin
        sel_word = src_data[i*WIDTH +: WIDTH];
        sel_ok   = 1'b1;
      end
    end
  end

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    err_d   = err_q;
    if (flush) begin
      data_d  = RST_VAL;
      valid_d = 1'b0;
      err_d   = 1'b0;
    end else if (!stall) begin
      data_d  = sel_word;
      valid_d = in_valid;
      err_d   = in_valid & ~sel_ok;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= RST_VAL;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign out_data    = data_q;
  assign out_valid   = valid_q;
  assign out_sel_err = err_q;

`ifdef OPSEL_STALL_CNT_EN
  logic [7:0] cnt_d, cnt_q;

  // Counts held edges, saturating; any flush or load edge clears it.
  always_comb begin
    cnt_d = 8'd0;
    if (stall && !flush) begin
      cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign stall_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_operand_sel_stage.sv
// Bench for operand_sel_stage: three instances (4x32, 3x32 with out-of-range selects, 2x5),
// directed table plus random stimulus against a behavioural model.
module tb_operand_sel_stage;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid, stall, flush;

  logic [3:0][31:0] a_src, b_src, c_src;
  logic [1:0]       a_sel, b_sel;
  logic [0:0]       c_sel;

  logic [31:0] a_data, b_data;
  logic [4:0]  c_data;
  logic        a_valid, b_valid, c_valid;
  logic        a_err, b_err, c_err;
`ifdef OPSEL_STALL_CNT_EN
  logic [7:0]  a_cnt, b_cnt, c_cnt;
`endif

  logic [95:0] b_flat;
  logic [9:0]  c_flat;
  assign b_flat = {b_src[2], b_src[1], b_src[0]};
  assign c_flat = {c_src[1][4:0], c_src[0][4:0]};

  always #5 clk = ~clk;

  operand_sel_stage #(.WIDTH(32), .NSRC(4), .SELW(2), .RST_VAL(32'h0)) u_a (
    .clk(clk), .rst_n(rst_n), .src_data(a_src), .sel(a_sel), .in_valid(in_valid),
    .stall(stall), .flush(flush), .out_data(a_data), .out_valid(a_valid), .out_sel_err(a_err)
`ifdef OPSEL_STALL_CNT_EN
    , .stall_cnt(a_cnt)
`endif
  );

  operand_sel_stage #(.WIDTH(32), .NSRC(3), .SELW(2), .RST_VAL(32'h0)) u_b (
    .clk(clk), .rst_n(rst_n), .src_data(b_flat), .sel(b_sel), .in_valid(in_valid),
    .stall(stall), .flush(flush), .out_data(b_data), .out_valid(b_valid), .out_sel_err(b_err)
`ifdef OPSEL_STALL_CNT_EN
    , .stall_cnt(b_cnt)
`endif
  );

  operand_sel_stage #(.WIDTH(5), .NSRC(2), .SELW(1), .RST_VAL(5'h0)) u_c (
    .clk(clk), .rst_n(rst_n), .src_data(c_flat), .sel(c_sel), .in_valid(in_valid),
    .stall(stall), .flush(flush), .out_data(c_data), .out_valid(c_valid), .out_sel_err(c_err)
`ifdef OPSEL_STALL_CNT_EN
    , .stall_cnt(c_cnt)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [31:0] data;
    logic        valid;
    logic        err;
    int          cnt;
  } mstate_t;

  mstate_t ma, mb, mc;

  function automatic mstate_t mreset();
    mstate_t r;
    r.data = 32'h0; r.valid = 1'b0; r.err = 1'b0; r.cnt = 0;
    return r;
  endfunction

  // Spec-level behaviour: flush beats stall beats load; counter saturates at 255.
  function automatic mstate_t mnext(mstate_t s, logic fl, logic st, logic iv, int sel, int nsrc,
                                    logic [3:0][31:0] src, logic [31:0] mask);
    mstate_t n = s;
    if (fl) begin
      n = mreset();
    end else if (st) begin
      if (s.cnt < 255) n.cnt = s.cnt + 1;
    end else begin
      n.cnt   = 0;
      n.valid = iv;
      if (sel < nsrc) begin
        n.data = src[sel] & mask;
        n.err  = 1'b0;
      end else begin
        n.data = 32'h0;
        n.err  = iv;
      end
    end
    return n;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("a_data", a_data, ma.data);
    chk("a_valid", 32'(a_valid), 32'(ma.valid));
    chk("a_err", 32'(a_err), 32'(ma.err));
    chk("b_data", b_data, mb.data);
    chk("b_valid", 32'(b_valid), 32'(mb.valid));
    chk("b_err", 32'(b_err), 32'(mb.err));
    chk("c_data", 32'(c_data), mc.data);
    chk("c_valid", 32'(c_valid), 32'(mc.valid));
    chk("c_err", 32'(c_err), 32'(mc.err));
`ifdef OPSEL_STALL_CNT_EN
    chk("a_cnt", 32'(a_cnt), ma.cnt);
    chk("b_cnt", 32'(b_cnt), mb.cnt);
    chk("c_cnt", 32'(c_cnt), mc.cnt);
`endif
  endtask

  task automatic step();
    ma = mnext(ma, flush, stall, in_valid, int'(a_sel), 4, a_src, 32'hFFFF_FFFF);
    mb = mnext(mb, flush, stall, in_valid, int'(b_sel), 3, b_src, 32'hFFFF_FFFF);
    mc = mnext(mc, flush, stall, in_valid, int'(c_sel), 2, c_src, 32'h0000_001F);
    @(posedge clk);
    #1;
    check_all();
  endtask

  typedef struct {
    logic             fl, st, iv;
    logic [1:0]       sel;
    logic [3:0][31:0] src;
    logic [31:0]      exp_data;
    logic             exp_valid, exp_err;
    int               exp_cnt;
  } vec_t;

  function automatic vec_t mk(logic fl, logic st, logic iv, logic [1:0] sel, logic [3:0][31:0] src,
                              logic [31:0] ed, logic ev, logic ee, int ec);
    vec_t v;
    v.fl = fl; v.st = st; v.iv = iv; v.sel = sel; v.src = src;
    v.exp_data = ed; v.exp_valid = ev; v.exp_err = ee; v.exp_cnt = ec;
    return v;
  endfunction

  vec_t tbl[16];

  initial begin
    logic [3:0][31:0] s_std, s_ld, s_alt, s_a5;

    s_std = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0000_0000};
    s_ld  = s_std;
    s_ld[1] = 32'h1234_5678;
    s_alt = {32'hCAFE_0003, 32'hCAFE_0002, 32'hCAFE_0001, 32'hCAFE_0000};
    s_a5  = s_std;
    s_a5[0] = 32'hA5A5_A5A5;

    //            fl    st    iv    sel    src    exp_data        v     e     cnt
    tbl[0]  = mk(1'b0, 1'b0, 1'b1, 2'd0, s_std, 32'h0000_0000, 1'b1, 1'b0, 0);
    tbl[1]  = mk(1'b0, 1'b0, 1'b1, 2'd1, s_std, 32'h1111_1111, 1'b1, 1'b0, 0);
    tbl[2]  = mk(1'b0, 1'b0, 1'b1, 2'd2, s_std, 32'h2222_2222, 1'b1, 1'b0, 0);
    tbl[3]  = mk(1'b0, 1'b0, 1'b1, 2'd3, s_std, 32'h3333_3333, 1'b1, 1'b0, 0);
    tbl[4]  = mk(1'b0, 1'b0, 1'b0, 2'd2, s_std, 32'h2222_2222, 1'b0, 1'b0, 0);
    tbl[5]  = mk(1'b0, 1'b0, 1'b1, 2'd1, s_ld,  32'h1234_5678, 1'b1, 1'b0, 0);
    tbl[6]  = mk(1'b0, 1'b1, 1'b0, 2'd0, s_alt, 32'h1234_5678, 1'b1, 1'b0, 1);
    tbl[7]  = mk(1'b0, 1'b1, 1'b1, 2'd2, s_std, 32'h1234_5678, 1'b1, 1'b0, 2);
    tbl[8]  = mk(1'b0, 1'b1, 1'b0, 2'd3, s_alt, 32'h1234_5678, 1'b1, 1'b0, 3);
    tbl[9]  = mk(1'b0, 1'b1, 1'b1, 2'd1, s_alt, 32'h1234_5678, 1'b1, 1'b0, 4);
    tbl[10] = mk(1'b0, 1'b1, 1'b0, 2'd2, s_std, 32'h1234_5678, 1'b1, 1'b0, 5);
    tbl[11] = mk(1'b0, 1'b0, 1'b1, 2'd3, s_std, 32'h3333_3333, 1'b1, 1'b0, 0);
    tbl[12] = mk(1'b0, 1'b1, 1'b0, 2'd0, s_alt, 32'h3333_3333, 1'b1, 1'b0, 1);
    tbl[13] = mk(1'b1, 1'b1, 1'b1, 2'd1, s_std, 32'h0000_0000, 1'b0, 1'b0, 0);
    tbl[14] = mk(1'b0, 1'b0, 1'b1, 2'd0, s_a5,  32'hA5A5_A5A5, 1'b1, 1'b0, 0);
    tbl[15] = mk(1'b1, 1'b0, 1'b1, 2'd2, s_std, 32'h0000_0000, 1'b0, 1'b0, 0);

    rst_n = 1'b0; in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    a_src = '0; b_src = '0; c_src = '0; a_sel = '0; b_sel = '0; c_sel = '0;
    ma = mreset(); mb = mreset(); mc = mreset();

    #12;
    check_all();
    rst_n = 1'b1;

    // Release then first capture.
    in_valid = 1'b1; a_sel = 2'd2; a_src[2] = 32'hDEAD_BEEF;
    step();
    chk("rel_data", a_data, 32'hDEAD_BEEF);
    chk("rel_valid", 32'(a_valid), 32'd1);

    // Reset dropped mid-cycle while stalled clears outputs before any edge.
    stall = 1'b1;
    step();
    chk("stall_hold", a_data, 32'hDEAD_BEEF);
    #3 rst_n = 1'b0;
    #1;
    ma = mreset(); mb = mreset(); mc = mreset();
    chk("async_data", a_data, 32'h0);
    chk("async_valid", 32'(a_valid), 32'd0);
    check_all();
    @(posedge clk);
    #1;
    check_all();
    #3 rst_n = 1'b1;
    stall = 1'b0;

    for (int k = 0; k < 16; k++) begin
      flush = tbl[k].fl; stall = tbl[k].st; in_valid = tbl[k].iv;
      a_sel = tbl[k].sel; a_src = tbl[k].src;
      step();
      chk($sformatf("tbl%0d_data", k), a_data, tbl[k].exp_data);
      chk($sformatf("tbl%0d_valid", k), 32'(a_valid), 32'(tbl[k].exp_valid));
      chk($sformatf("tbl%0d_err", k), 32'(a_err), 32'(tbl[k].exp_err));
`ifdef OPSEL_STALL_CNT_EN
      chk($sformatf("tbl%0d_cnt", k), 32'(a_cnt), tbl[k].exp_cnt);
`endif
    end

    // Out-of-range select on the 3-source instance.
    flush = 1'b0; stall = 1'b0; in_valid = 1'b1;
    b_src[0] = 32'hCCCC_0000; b_src[1] = 32'hBBBB_1111; b_src[2] = 32'hAAAA_2222; b_src[3] = 32'hFFFF_FFFF;
    b_sel = 2'd3;
    step();
    chk("oor_data", b_data, 32'h0);
    chk("oor_valid", 32'(b_valid), 32'd1);
    chk("oor_err", 32'(b_err), 32'd1);
    in_valid = 1'b0;
    step();
    chk("oor_iv0_err", 32'(b_err), 32'd0);
    chk("oor_iv0_valid", 32'(b_valid), 32'd0);
    in_valid = 1'b1; b_sel = 2'd2;
    step();
    chk("inr_data", b_data, 32'hAAAA_2222);
    chk("inr_err", 32'(b_err), 32'd0);

    // Narrow rt/rd select, then a long stall to saturate the counter.
    c_src[0] = 32'd8; c_src[1] = 32'd31;
    for (int k = 0; k < 6; k++) begin
      c_sel = 1'(k & 1);
      step();
      chk($sformatf("narrow%0d", k), 32'(c_data), (k & 1) ? 32'd31 : 32'd8);
    end
    stall = 1'b1;
    c_sel = 1'b0;
    for (int k = 0; k < 300; k++) step();
    chk("sat_hold", 32'(c_data), 32'd31);
`ifdef OPSEL_STALL_CNT_EN
    chk("sat_cnt", 32'(c_cnt), 32'd255);
`endif
    stall = 1'b0;
    step();
    chk("sat_release", 32'(c_data), 32'd8);
`ifdef OPSEL_STALL_CNT_EN
    chk("sat_clear", 32'(c_cnt), 32'd0);
`endif

    for (int k = 0; k < 400; k++) begin
      flush    = ($urandom_range(0, 7) == 0);
      stall    = ($urandom_range(0, 3) == 0);
      in_valid = 1'($urandom);
      a_sel    = 2'($urandom);
      b_sel    = 2'($urandom);
      c_sel    = 1'($urandom);
      for (int j = 0; j < 4; j++) begin
        a_src[j] = $urandom;
        b_src[j] = $urandom;
        c_src[j] = $urandom & 32'h1F;
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/operand_sel_stage.md
Name: operand_sel_stage

Overview:
- Parametrised operand selector with a registered output, replacing the fixed 2:1 datapath selects (destination register, ALU B-operand, writeback data) with one N-source, W-bit block.
- Output is registered, so the block also serves as the pipeline register slice for the selected field, with stall (hold) and flush (bubble) control.
- Sits between pipeline stages (ID/EX, MEM/WB) and drives the consuming stage's operand input.

Parameters:
- WIDTH, 32, bit width of each source and of the output (5 for register-number selects).
- NSRC, 4, number of sources, 2..16.
- SELW, 2, select width; must satisfy 2**SELW >= NSRC (integrator sets it; the block does not compute it).
- RST_VAL, 0, value of out_data after reset and after flush.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- src_data  input  NSRC*WIDTH  flattened sources; source i occupies bits [i*WIDTH +: WIDTH].
- sel  input  SELW  source index.
- in_valid  input  1  the upstream stage holds a real instruction.
- stall  input  1  hold the current output.
- flush  input  1  insert a bubble.
- out_data  output  WIDTH  registered selected data.
- out_valid  output  1  registered valid.
- out_sel_err  output  1  registered flag: the captured select was out of range.
- stall_cnt  output  8  present only with the optional feature (see below).

Behaviour:
- Reset (rst_n low, asynchronous, takes effect immediately, regardless of clk):
  - out_data = RST_VAL, out_valid = 0, out_sel_err = 0, stall_cnt = 0.
  - Release is synchronous to the next rising edge; the first capture happens on the first edge with rst_n high.
- Latency: 1 cycle. Inputs sampled on edge k appear on the outputs after edge k. No combinational path from any input to any output.
- Per-edge priority: flush > stall > load.
  - flush=1: out_data <= RST_VAL, out_valid <= 0, out_sel_err <= 0. Stall is ignored that cycle.
  - stall=1, flush=0: all outputs hold. in_valid, sel and src_data are ignored.
  - load (flush=0, stall=0), sel < NSRC: out_data <= src_data[sel*WIDTH +: WIDTH], out_valid <= in_valid, out_sel_err <= 0.
  - load, sel >= NSRC (possible only when 2**SELW > NSRC): out_data <= RST_VAL, out_valid <= in_valid, out_sel_err <= in_valid.
- Data is captured even when in_valid=0, so out_data may hold stale or junk values while out_valid=0. Consumers must qualify with out_valid.
- Stall duration is unbounded. The output stays bit-stable for the whole stall.
- Reset asserted mid-stall or mid-flush overrides both immediately.
- No internal state beyond the output registers (and stall_cnt when enabled).

Optional Feature:
- Macro: OPSEL_STALL_CNT_EN.
- Defined:
  - Port stall_cnt[7:0] exists.
  - It increments by 1 on each edge where stall=1 and flush=0, saturating at 255.
  - It clears to 0 on any edge that flushes or loads, and on reset.
  - Purpose: lets the hazard unit and the bench observe the length of the current stall.
- Not defined: the port and its counter logic are absent. All other behaviour is identical.

Test Plan:
1. Reset: drive rst_n=0 between edges -> outputs go to 0 before the next edge; after release with in_valid=1, sel=2, src2=0xDEADBEEF -> one edge later out_data=0xDEADBEEF, out_valid=1.
2. Full sweep, NSRC=4: sources i*0x11111111, sel cycling 0..3 on consecutive cycles -> out_data tracks the sequence one cycle late, out_sel_err=0 throughout.
3. Stall: load 0x12345678, hold stall=1 for 5 cycles while changing sel and src -> out_data stays 0x12345678, out_valid=1 throughout; with OPSEL_STALL_CNT_EN, stall_cnt reads 1..5, then 0 on the first load after release.
4. Flush beats stall: flush=1 and stall=1 on the same edge -> out_valid=0, out_data=RST_VAL; the next load edge captures normally.
5. Out-of-range select, NSRC=3, SELW=2: sel=3, in_valid=1 -> out_data=0, out_valid=1, out_sel_err=1; same with in_valid=0 -> out_sel_err=0.
6. Narrow instance, WIDTH=5, NSRC=2 (rt/rd select): rt=5'd8, rd=5'd31, sel toggling -> out_data alternates 8/31 one cycle late; with OPSEL_STALL_CNT_EN, hold stall for 300 cycles -> stall_cnt saturates at 255.
